// File: rtl/y86_decode_regfile.sv
// Y86-64 decode/writeback stage: register file, source/destination ID generation,
// operand selection and the E pipeline register. Forwarding network gated by DECODE_FWD_EN.
module y86_decode_regfile #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [WIDTH-1:0] D_valP,
    input  logic             E_bubble,
    input  logic             E_stall,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB
);
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] I_NOP = 4'h1;

    logic [3:0]       src_a, src_b, dst_e, dst_m;
    logic [WIDTH-1:0] rf_a, rf_b, val_a, val_b;
    logic [WIDTH-1:0] rf_q [0:14];
    logic [WIDTH-1:0] rf_d [0:14];

    logic [3:0]       ex_icode_q, ex_icode_d, ex_ifun_q, ex_ifun_d;
    logic [WIDTH-1:0] ex_valc_q, ex_valc_d, ex_vala_q, ex_vala_d, ex_valb_q, ex_valb_d;
    logic [3:0]       ex_dste_q, ex_dste_d, ex_dstm_q, ex_dstm_d;
    logic [3:0]       ex_srca_q, ex_srca_d, ex_srcb_q, ex_srcb_d;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = D_rA;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       src_b = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       dst_e = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
            default:                dst_e = RNONE;
        endcase
        case (D_icode)
            4'h5, 4'hB:             dst_m = D_rA;
            default:                dst_m = RNONE;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // RNONE reads as zero; the array itself has no slot for it.
    assign rf_a = (src_a == RNONE) ? '0 : rf_q[src_a];
    assign rf_b = (src_b == RNONE) ? '0 : rf_q[src_b];

`ifdef DECODE_FWD_EN
    always_comb begin
        val_a = rf_a;
        val_b = rf_b;
        if (src_a != RNONE) begin
            if      (src_a == e_dstE) val_a = e_valE;
            else if (src_a == M_dstM) val_a = m_valM;
            else if (src_a == M_dstE) val_a = M_valE;
            else if (src_a == W_dstM) val_a = W_valM;
            else if (src_a == W_dstE) val_a = W_valE;
        end
        if (src_b != RNONE) begin
            if      (src_b == e_dstE) val_b = e_valE;
            else if (src_b == M_dstM) val_b = m_valM;
            else if (src_b == M_dstE) val_b = M_valE;
            else if (src_b == W_dstM) val_b = W_valM;
            else if (src_b == W_dstE) val_b = W_valE;
        end
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    end
`else
    // Without forwarding the hazard unit stalls; bypass inputs are intentionally dropped.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};

    always_comb begin
        val_a = rf_a;
        val_b = rf_b;
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    end
`endif

    // popq %rsp: the M write is applied last so it wins over the E write.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            rf_d[i] = rf_q[i];
            if (W_dstE != RNONE && W_dstE == 4'(i)) rf_d[i] = W_valE;
            if (W_dstM != RNONE && W_dstM == 4'(i)) rf_d[i] = W_valM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        ex_icode_d = ex_icode_q;
        ex_ifun_d  = ex_ifun_q;
        ex_valc_d  = ex_valc_q;
        ex_vala_d  = ex_vala_q;
        ex_valb_d  = ex_valb_q;
        ex_dste_d  = ex_dste_q;
        ex_dstm_d  = ex_dstm_q;
        ex_srca_d  = ex_srca_q;
        ex_srcb_d  = ex_srcb_q;
        if (E_bubble) begin
            ex_icode_d = I_NOP;
            ex_ifun_d  = 4'h0;
            ex_valc_d  = '0;
            ex_vala_d  = '0;
            ex_valb_d  = '0;
            ex_dste_d  = RNONE;
            ex_dstm_d  = RNONE;
            ex_srca_d  = RNONE;
            ex_srcb_d  = RNONE;
        end else if (!E_stall) begin
            ex_icode_d = D_icode;
            ex_ifun_d  = D_ifun;
            ex_valc_d  = D_valC;
            ex_vala_d  = val_a;
            ex_valb_d  = val_b;
            ex_dste_d  = dst_e;
            ex_dstm_d  = dst_m;
            ex_srca_d  = src_a;
            ex_srcb_d  = src_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_icode_q <= I_NOP;
            ex_ifun_q  <= 4'h0;
            ex_valc_q  <= '0;
            ex_vala_q  <= '0;
            ex_valb_q  <= '0;
            ex_dste_q  <= RNONE;
            ex_dstm_q  <= RNONE;
            ex_srca_q  <= RNONE;
            ex_srcb_q  <= RNONE;
        end else begin
            ex_icode_q <= ex_icode_d;
            ex_ifun_q  <= ex_ifun_d;
            ex_valc_q  <= ex_valc_d;
            ex_vala_q  <= ex_vala_d;
            ex_valb_q  <= ex_valb_d;
            ex_dste_q  <= ex_dste_d;
            ex_dstm_q  <= ex_dstm_d;
            ex_srca_q  <= ex_srca_d;
            ex_srcb_q  <= ex_srcb_d;
        end
    end

    assign E_icode = ex_icode_q;
    assign E_ifun  = ex_ifun_q;
    assign E_valC  = ex_valc_q;
    assign E_valA  = ex_vala_q;
    assign E_valB  = ex_valb_q;
    assign E_dstE  = ex_dste_q;
    assign E_dstM  = ex_dstm_q;
    assign E_srcA  = ex_srca_q;
    assign E_srcB  = ex_srcb_q;
endmodule
